// File: rtl/tpu_package.sv
// Shared TPU constants and weight-fetch FSM state type.
// Row geometry and address width are fixed here for all TPU blocks.
package tpu_package;

  localparam int MUL_SIZE      = 32;
  localparam int WEIGHT_W      = 8;
  localparam int WEIGHT_ADDR_W = 16;
  localparam int ROW_W         = MUL_SIZE * WEIGHT_W;
  localparam int TILE_W        = 8;
  localparam int ROW_CNT_W     = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } wfu_state_e;

  function automatic logic [ROW_CNT_W-1:0] tile_rows(
    input logic [TILE_W-1:0] tiles
  );
    return ROW_CNT_W'(tiles) << $clog2(MUL_SIZE);
  endfunction

endpackage

// File: rtl/weight_skid_buffer.sv
// Two-entry FIFO that absorbs weight rows returning from memory
// while the downstream weight FIFO is stalled.
module weight_skid_buffer
  import tpu_package::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ROW_W-1:0] data_i,
  output logic [ROW_W-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [ROW_W-1:0] ent0_q, ent0_d;
  logic [ROW_W-1:0] ent1_q, ent1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      if (wr_ptr_q) ent1_d = data_i;
      else          ent0_d = data_i;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = rd_ptr_q ? ent1_q : ent0_q;
  assign count_o = count_q;

endmodule

// File: rtl/weight_fetch_unit.sv
// Streams num_tiles*MUL_SIZE weight rows from memory into the weight
// FIFO, throttling reads so the skid buffer can never overflow.
module weight_fetch_unit
  import tpu_package::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instruction_i,
  input  logic [WEIGHT_ADDR_W-1:0] base_addr_i,
  input  logic [TILE_W-1:0]        num_tiles_i,
  output logic                     mem_rd_en_o,
  output logic [WEIGHT_ADDR_W-1:0] mem_rd_addr_o,
  input  logic [ROW_W-1:0]         mem_rd_data_i,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [ROW_W-1:0]         fifo_wr_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  wfu_state_e               state_q, state_d;
  logic [WEIGHT_ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_CNT_W-1:0]     rd_left_q, rd_left_d;
  logic [ROW_CNT_W-1:0]     wr_left_q, wr_left_d;
  logic                     inflight_q, inflight_d;

  logic [1:0]       skid_count;
  logic [ROW_W-1:0] skid_data;
  logic             skid_pop;
  logic [1:0]       occ_next;
  logic             rd_en;

  weight_skid_buffer u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .pop_i   (skid_pop),
    .data_i  (mem_rd_data_i),
    .data_o  (skid_data),
    .count_o (skid_count)
  );

  // Occupancy the skid will hold when a read issued now returns.
  always_comb begin
    skid_pop = (skid_count != 2'd0) && !fifo_full_i;
    occ_next = skid_count + {1'b0, inflight_q} - {1'b0, skid_pop};
    rd_en    = (state_q == ST_FETCH) && (rd_left_q != '0)
            && (occ_next < 2'd2);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    inflight_d = rd_en;
    if (rd_en) begin
      addr_d    = addr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
    end
    if (skid_pop) begin
      wr_left_d = wr_left_q - 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (instruction_i) begin
          addr_d    = base_addr_i;
          rd_left_d = tile_rows(num_tiles_i);
          wr_left_d = tile_rows(num_tiles_i);
          state_d   = (num_tiles_i != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (rd_en && rd_left_q == ROW_CNT_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (skid_pop && wr_left_q == ROW_CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      inflight_q <= inflight_d;
    end
  end

  assign mem_rd_en_o    = rd_en;
  assign mem_rd_addr_o  = addr_q;
  assign fifo_wr_en_o   = skid_pop;
  assign fifo_wr_data_o = skid_data;
  assign busy_o         = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit: command table plus reset
// and re-issue sequences, checked against a memory/row-order model.
module tb_weight_fetch_unit;
  import tpu_package::*;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     instruction_i = 1'b0;
  logic [WEIGHT_ADDR_W-1:0] base_addr_i = '0;
  logic [TILE_W-1:0]        num_tiles_i = '0;
  logic                     mem_rd_en_o;
  logic [WEIGHT_ADDR_W-1:0] mem_rd_addr_o;
  logic [ROW_W-1:0]         mem_rd_data_i = '0;
  logic                     fifo_full_i = 1'b0;
  logic                     fifo_wr_en_o;
  logic [ROW_W-1:0]         fifo_wr_data_o;
  logic                     busy_o;
  logic                     done_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  tiles;
    int          full_lo;
    int          full_hi;
    bit          rand_full;
    int          exp_rows;
    int          exp_lat;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  weight_fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instruction_i  (instruction_i),
    .base_addr_i    (base_addr_i),
    .num_tiles_i    (num_tiles_i),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_rd_addr_o  (mem_rd_addr_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  function automatic logic [ROW_W-1:0] row_of(input logic [15:0] a);
    return {8{a, ~a}};
  endfunction

  // One-cycle-latency weight memory.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= row_of(mem_rd_addr_o);
  end

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check(nm, longint'(mem_rd_en_o | fifo_wr_en_o | busy_o | done_o
                       | (|mem_rd_addr_o) | (|fifo_wr_data_o)), 0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag,
                         input int repulse_k, input int abort_row);
    int nrd = 0, nwr = 0, ndone = 0;
    int first_rd = -1, first_wr = -1, last_wr = -1, done_k = -1;
    int addr_err = 0, data_err = 0, full_err = 0;
    int out_err = 0, busy_err = 0;
    bit full_now;
    @(negedge clk);
    instruction_i = 1'b1;
    base_addr_i   = v.base;
    num_tiles_i   = v.tiles;
    fifo_full_i   = 1'b0;
    for (int k = 1; k < 20000; k++) begin
      @(negedge clk);
      instruction_i = (k == repulse_k);
      base_addr_i   = 16'h5000;
      num_tiles_i   = 8'd3;
      if (v.rand_full) full_now = ($urandom_range(0, 2) == 0);
      else full_now = (k >= v.full_lo) && (k <= v.full_hi);
      fifo_full_i = full_now;
      #1;
      if (mem_rd_en_o) begin
        if (mem_rd_addr_o !== 16'(v.base + nrd)) addr_err++;
        if (first_rd < 0) first_rd = k;
        nrd++;
      end
      if (fifo_wr_en_o) begin
        if (full_now) full_err++;
        if (fifo_wr_data_o !== row_of(16'(v.base + nwr))) data_err++;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
        nwr++;
      end
      if (nrd - nwr > 2) out_err++;
      if (busy_o !== (v.tiles != 0 && done_k < 0 && !done_o)) busy_err++;
      if (done_o) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (abort_row >= 0 && nwr == abort_row) return;
      if (done_k >= 0 && k == done_k + 2) break;
    end
    check({tag, " completed"}, longint'(done_k >= 0), 1);
    check({tag, " reads"}, nrd, v.exp_rows);
    check({tag, " writes"}, nwr, v.exp_rows);
    check({tag, " addr order errs"}, addr_err, 0);
    check({tag, " row data errs"}, data_err, 0);
    check({tag, " write while full"}, full_err, 0);
    check({tag, " outstanding >2"}, out_err, 0);
    check({tag, " busy errs"}, busy_err, 0);
    check({tag, " done pulses"}, ndone, 1);
    if (v.exp_lat >= 0) begin
      check({tag, " first write latency"}, first_wr - first_rd, v.exp_lat);
      check({tag, " write span"}, last_wr - first_wr, v.exp_rows - 1);
    end
    if (v.exp_done >= 0) check({tag, " done cycle"}, done_k, v.exp_done);
    else check({tag, " done after last write"}, done_k, last_wr + 1);
  endtask

  initial begin
    vec_t va;
    vecs[0] = '{16'h0100, 8'd1, -1, -2, 1'b0, 32, 2, 35};
    vecs[1] = '{16'h1000, 8'd2, 5, 14, 1'b0, 64, -1, -1};
    vecs[2] = '{16'h2222, 8'd0, -1, -2, 1'b0, 0, -1, 1};
    vecs[3] = '{16'hFFF0, 8'd1, -1, -2, 1'b0, 32, 2, 35};
    vecs[4] = '{16'h0040, 8'd3, -1, -2, 1'b1, 96, -1, -1};
    vecs[5] = '{16'h8000, 8'd255, -1, -2, 1'b0, 8160, 2, 8163};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset outputs");
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i), -1, -1);
    end

    // Reset while row 10 of tile 0 is being written.
    va = '{16'h0200, 8'd1, -1, -2, 1'b0, 32, 2, 35};
    run_cmd(va, "abort", -1, 10);
    rst_i = 1'b1;
    @(negedge clk);
    fifo_full_i = 1'b0;
    instruction_i = 1'b0;
    #1;
    check_zero("mid-fetch reset outputs");
    rst_i = 1'b0;
    va = '{16'h0300, 8'd1, -1, -2, 1'b0, 32, 2, 35};
    run_cmd(va, "after reset", -1, -1);

    // Second instruction during FETCH must not restart the command.
    va = '{16'h0400, 8'd1, -1, -2, 1'b0, 32, 2, 35};
    run_cmd(va, "repulse", 5, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
